// File: rtl/perf_hist.sv
// perf_hist: per-channel occupancy histograms, retire event counters and a
// retire-stall watchdog (built only when PERF_HIST_WDOG_EN is defined), read through a 1-cycle port.
module perf_hist #(
  parameter int CHANNELS   = 3,
  parameter int OCC_W      = 8,
  parameter int BINS       = 16,
  parameter int BIN_SHIFT  = 3,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 2000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [CHANNELS*OCC_W-1:0]       occ,
  input  logic                            ret_valid,
  input  logic                            ret_branch,
  input  logic                            ret_mispred,
  input  logic                            clr,
  input  logic                            rd_req,
  input  logic [$clog2(CHANNELS+1)-1:0]   rd_chan,
  input  logic [$clog2(BINS)-1:0]         rd_bin,
  output logic                            rd_valid,
  output logic [CNT_W-1:0]                rd_data,
  output logic                            wdog_trip
);

  localparam int BIN_W = $clog2(BINS);
  localparam int CH_W  = $clog2(CHANNELS+1);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Sample stage 1: shift and clamp each occupancy into a bin index
  // ---------------------------------------------------------------------------
  logic [63:0]      occ_shift [CHANNELS];
  logic [BIN_W-1:0] bin_d     [CHANNELS];
  logic [BIN_W-1:0] s1_bin    [CHANNELS];
  logic             s1_valid;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      occ_shift[c] = 64'(occ[c*OCC_W +: OCC_W]) >> BIN_SHIFT;
      bin_d[c]     = BIN_W'(BINS-1);
      if (occ_shift[c] <= 64'(BINS-1))
        bin_d[c] = occ_shift[c][BIN_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sample stage 2: saturating histogram bins
  // ---------------------------------------------------------------------------
  cnt_t hist [CHANNELS][BINS];

  // NOTE: sequential state is written with non-blocking assignments only.
  // NOTE: the bin array is readable state and must read 0 after reset, so it is reset like any register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        s1_bin[c] <= '0;
        for (int b = 0; b < BINS; b++) hist[c][b] <= '0;
      end
    end else if (clr) begin
      // The new sample and any stage-2 increment in flight are both dropped.
      s1_valid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int b = 0; b < BINS; b++) hist[c][b] <= '0;
    end else begin
      s1_valid <= en;
      if (en) s1_bin <= bin_d;
      if (s1_valid)
        for (int c = 0; c < CHANNELS; c++)
          hist[c][s1_bin[c]] <= sat_inc(hist[c][s1_bin[c]]);
    end
  end

  // ---------------------------------------------------------------------------
  // Event bank: updates in the cycle of the event, no pipeline
  // ---------------------------------------------------------------------------
  cnt_t ev_cycles, ev_instret, ev_branches, ev_mispreds;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_cycles   <= '0;
      ev_instret  <= '0;
      ev_branches <= '0;
      ev_mispreds <= '0;
    end else if (clr) begin
      ev_cycles   <= '0;
      ev_instret  <= '0;
      ev_branches <= '0;
      ev_mispreds <= '0;
    end else begin
      if (en)                                     ev_cycles   <= sat_inc(ev_cycles);
      if (ret_valid)                              ev_instret  <= sat_inc(ev_instret);
      if (ret_valid && ret_branch)                ev_branches <= sat_inc(ev_branches);
      if (ret_valid && ret_branch && ret_mispred) ev_mispreds <= sat_inc(ev_mispreds);
    end
  end

  // ---------------------------------------------------------------------------
  // Read port: mux of current (pre-update) counter values, registered once
  // ---------------------------------------------------------------------------
  cnt_t rd_mux;

  always_comb begin
    rd_mux = '0;
    if (rd_chan == CH_W'(CHANNELS)) begin
      case (int'(rd_bin))
        0:       rd_mux = ev_cycles;
        1:       rd_mux = ev_instret;
        2:       rd_mux = ev_branches;
        3:       rd_mux = ev_mispreds;
        default: rd_mux = '0;
      endcase
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        if (rd_chan == CH_W'(c)) rd_mux = hist[c][rd_bin];
    end
  end

  // Reads ignore clr so a read in the clear cycle returns the pre-clear value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux;
    end
  end

  // ---------------------------------------------------------------------------
  // Retire-stall watchdog
  // ---------------------------------------------------------------------------
`ifdef PERF_HIST_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT+1);

  logic [WD_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      wdog_trip <= 1'b0;
    end else if (clr) begin
      stall_cnt <= '0;
      wdog_trip <= 1'b0;
    end else begin
      if (ret_valid)
        stall_cnt <= '0;
      else if (en && stall_cnt != WD_W'(WDOG_LIMIT))
        stall_cnt <= stall_cnt + WD_W'(1);
      // A retire in the trip cycle wins over the trip.
      if (!ret_valid && stall_cnt == WD_W'(WDOG_LIMIT))
        wdog_trip <= 1'b1;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_perf_hist.sv
// Scoreboard bench for perf_hist: expected read data queued at request, checked on rd_valid.
module tb_perf_hist;

  localparam int CHANNELS = 3;
  localparam int OCC_W    = 8;
  localparam int BINS     = 16;
  localparam int CNT_W    = 8;
  localparam int LIMIT    = 2000;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          en;
  logic [CHANNELS*OCC_W-1:0]     occ;
  logic                          ret_valid, ret_branch, ret_mispred;
  logic                          clr;
  logic                          rd_req;
  logic [$clog2(CHANNELS+1)-1:0] rd_chan;
  logic [$clog2(BINS)-1:0]       rd_bin;
  logic                          rd_valid;
  logic [CNT_W-1:0]              rd_data;
  logic                          wdog_trip;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] sb [$];

  perf_hist #(
    .CHANNELS(CHANNELS), .OCC_W(OCC_W), .BINS(BINS), .BIN_SHIFT(3),
    .CNT_W(CNT_W), .WDOG_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .occ(occ),
    .ret_valid(ret_valid), .ret_branch(ret_branch), .ret_mispred(ret_mispred),
    .clr(clr), .rd_req(rd_req), .rd_chan(rd_chan), .rd_bin(rd_bin),
    .rd_valid(rd_valid), .rd_data(rd_data), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  // Response monitor: every rd_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: rd_valid=1 data=%0d with no outstanding request", rd_data);
      end else begin
        logic [CNT_W-1:0] exp;
        exp = sb.pop_front();
        if (rd_data !== exp) begin
          failures++;
          $display("FAIL rd_data: got %0d expected %0d", rd_data, exp);
        end
      end
    end
  end

  task automatic cycle(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b0; occ = '0; ret_valid = 1'b0; ret_branch = 1'b0; ret_mispred = 1'b0;
    clr = 1'b0; rd_req = 1'b0; rd_chan = '0; rd_bin = '0;
  endtask

  task automatic set_occ(input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2);
    occ = {o2, o1, o0};
  endtask

  task automatic issue_read(input int ch, input int bin, input logic [CNT_W-1:0] exp);
    rd_req = 1'b1; rd_chan = 2'(ch); rd_bin = 4'(bin);
    sb.push_back(exp);
    cycle();
    rd_req = 1'b0;
  endtask

  // Every outstanding read must have returned within a short bound.
  task automatic drain(input string name);
    cycle(3);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d reads outstanding, expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic do_clear();
    clr = 1'b1; cycle(); clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    cycle(2);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || wdog_trip !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rd_valid=%b rd_data=%0d wdog_trip=%b expected 0/0/0",
               rd_valid, rd_data, wdog_trip);
    end
    rst = 1'b1;
    cycle();
    issue_read(0, 0, 0);
    issue_read(3, 0, 0);
    drain("reset");
  endtask

  task automatic test_hist();
    en = 1'b1; set_occ(8'h25, 8'h00, 8'h00);
    cycle(10);
    en = 1'b0;
    cycle();
    issue_read(0, 4, 10);
    issue_read(0, 3, 0);
    issue_read(1, 0, 10);
    issue_read(2, 0, 10);
    drain("hist");
  endtask

  task automatic test_clamp();
    do_clear();
    en = 1'b1; set_occ(8'h00, 8'hFF, 8'h00);
    cycle(5);
    en = 1'b0; cycle();
    issue_read(1, 15, 5);
    issue_read(1, 14, 0);
    en = 1'b1; cycle(295);
    en = 1'b0; cycle();
    issue_read(1, 15, 255);
    issue_read(0, 0, 255);
    drain("clamp");
  endtask

  task automatic test_events();
    do_clear();
    set_occ(8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      en          = 1'b1;
      ret_valid   = (i < 7);
      ret_branch  = (i < 3) || (i == 10);
      ret_mispred = (i == 0) || (i == 5) || (i == 10);
      cycle();
    end
    idle();
    cycle();
    issue_read(3, 0, 20);
    issue_read(3, 1, 7);
    issue_read(3, 2, 3);
    issue_read(3, 3, 1);
    issue_read(3, 5, 0);
    issue_read(3, 4, 0);
    issue_read(0, 0, 20);
    drain("events");
  endtask

  task automatic test_clr_collision();
    do_clear();
    en = 1'b1; set_occ(8'h25, 8'h00, 8'h00);
    cycle(10);
    en = 1'b0; cycle();
    en = 1'b1; clr = 1'b1;
    issue_read(0, 4, 10);
    en = 1'b0; clr = 1'b0;
    cycle();
    issue_read(0, 4, 0);
    issue_read(3, 0, 0);
    // Sample pending in stage 2 during clr is dropped too.
    en = 1'b1; cycle();
    en = 1'b0; clr = 1'b1; cycle();
    clr = 1'b0; cycle(2);
    issue_read(0, 4, 0);
    issue_read(3, 0, 0);
    drain("clr");
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] last;
    do_clear();
    set_occ(8'h00, 8'h00, 8'h10);
    last = '0;
    for (int k = 0; k < 6; k++) begin
      en = 1'b1;
      last = (k >= 1) ? CNT_W'(k - 1) : '0;
      issue_read(2, 2, last);
    end
    en = 1'b0;
    drain("b2b");
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== last) begin
      failures++;
      $display("FAIL rd_hold: rd_valid=%b rd_data=%0d expected 0/%0d", rd_valid, rd_data, last);
    end
  endtask

  task automatic check_trip(input string name, input logic exp);
    checks++;
    if (wdog_trip !== exp) begin
      failures++;
      $display("FAIL %s: wdog_trip=%b expected %b", name, wdog_trip, exp);
    end
  endtask

  task automatic test_wdog();
    logic on;
`ifdef PERF_HIST_WDOG_EN
    on = 1'b1;
`else
    on = 1'b0;
`endif
    do_clear();
    en = 1'b1;
    cycle(LIMIT);
    check_trip("wdog_before_limit", 1'b0);
    cycle();
    check_trip("wdog_trip", on);
    ret_valid = 1'b1; cycle(); ret_valid = 1'b0;
    cycle(2);
    check_trip("wdog_sticky", on);
    en = 1'b0;
    do_clear();
    check_trip("wdog_clr", 1'b0);
    en = 1'b1;
    cycle(LIMIT);
    ret_valid = 1'b1; cycle(); ret_valid = 1'b0;
    check_trip("wdog_ret_wins", 1'b0);
    cycle(5);
    check_trip("wdog_ret_wins_after", 1'b0);
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    en = 1'b1; set_occ(8'h00, 8'hFF, 8'h00);
    cycle(3);
    en = 1'b0; cycle();
    issue_read(1, 15, 3);
    cycle();
    // In flight: a sample and a read, both discarded by the reset.
    en = 1'b1;
    rd_req = 1'b1; rd_chan = 2'd1; rd_bin = 4'd15;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0 || wdog_trip !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: rd_valid=%b rd_data=%0d wdog_trip=%b expected 0/0/0",
               rd_valid, rd_data, wdog_trip);
    end
    sb.delete();
    idle();
    cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_valid: rd_valid=%b expected 0", rd_valid);
    end
    issue_read(1, 15, 0);
    issue_read(0, 0, 0);
    issue_read(3, 0, 0);
    issue_read(3, 1, 0);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_hist();
    test_clamp();
    test_events();
    test_clr_collision();
    test_back_to_back();
    test_wdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait ever hangs.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/perf_hist.md
# perf_hist

Synthesizable performance monitor: the hardware successor to the simulation-only occupancy histograms and retire statistics. Samples CHANNELS occupancy inputs (ROB, LQ, SQ, …) every enabled cycle into per-channel saturating histogram bins. Also counts cycles, retired instructions, branches and mispredicts, and flags a retire-stall watchdog. Sits beside the ROB/LSQ; all counters are read through a pipelined single-cycle-latency read port, for example behind a CSR window.

## Interface
- CHANNELS, 3: number of occupancy channels (1–8).
- OCC_W, 8: width of each occupancy input.
- BINS, 16: bins per channel; power of two, 2–64.
- BIN_SHIFT, 3: occupancy right-shift applied before binning.
- CNT_W, 32: width of every counter (8–64).
- WDOG_LIMIT, 2000: number of stall cycles before the watchdog trips.

- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-low
- en  in  1  sample enable; gates histogram, cycle and watchdog counting
- occ  in  CHANNELS*OCC_W  occupancy values; channel c is occ[c*OCC_W +: OCC_W]
- ret_valid  in  1  one instruction retired this cycle
- ret_branch  in  1  the retired instruction is a branch; qualified by ret_valid
- ret_mispred  in  1  the retired branch was mispredicted; qualified by ret_valid & ret_branch
- clr  in  1  synchronous clear of all counters and the watchdog flag
- rd_req  in  1  read request
- rd_chan  in  $clog2(CHANNELS+1)  channel select; value CHANNELS selects the event bank
- rd_bin  in  $clog2(BINS)  bin select, or event index within the event bank
- rd_valid  out  1  read data valid
- rd_data  out  CNT_W  read data
- wdog_trip  out  1  sticky watchdog flag

## Operation
- Reset (rst=0, asynchronous): all counters, pipeline registers, rd_valid, rd_data and wdog_trip go to 0.
- Sample stage 1, cycle t with en=1: for each channel, bin = occ_c >> BIN_SHIFT, clamped to BINS-1. Bin indices and a valid bit are registered.
- Sample stage 2, cycle t+1: the selected bin counter of each channel increments by 1.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Event bank, rd_chan==CHANNELS:
  - index 0: cycles, incremented when en=1
  - index 1: instret, incremented when ret_valid=1
  - index 2: branches, incremented when ret_valid & ret_branch
  - index 3: mispreds, incremented when ret_valid & ret_branch & ret_mispred
  - index ≥4 reads 0
  - The event bank updates in the same cycle as the event, with no pipeline.
- Read port:
  - rd_req in cycle t gives rd_valid=1 and rd_data in cycle t+1.
  - Back-to-back requests are accepted every cycle.
  - rd_data holds its last value while rd_valid=0.
  - A counter read in the same cycle it updates returns the pre-update value.
  - rd_chan > CHANNELS, or an out-of-range bin, returns 0.
- clr:
  - All counters, the stage-1 valid bit and wdog_trip are cleared at the next edge.
  - A sample or event in the clr cycle is dropped, and a stage-2 increment pending in that cycle is also dropped.
  - A read issued in the clr cycle returns the pre-clear value.
- en=0: no histogram sample enters stage 1. A sample already in stage 1 still commits. Event counters other than cycles still count.

## Timing
- Histogram latency: occ sampled at edge t is visible to an rd_req issued in cycle t+2.
- Read latency: 1 cycle, fully pipelined.
- Watchdog:
  - The stall counter resets to 0 on ret_valid or clr.
  - Otherwise it increments while en=1.
  - When the counter equals WDOG_LIMIT, wdog_trip goes to 1 at the next edge.
  - wdog_trip is sticky until clr or reset.
  - The stall counter saturates at WDOG_LIMIT.
- Simultaneous ret_valid and the trip condition: ret_valid wins and no trip occurs.
- Reset mid-operation: the in-flight sample and read are discarded, and rd_valid is 0 in the first cycle after rst deasserts.

## Configuration
- PERF_HIST_WDOG_EN:
  - Defined: the stall counter and wdog_trip are implemented as described above.
  - Undefined: no stall counter is built, wdog_trip is constant 0, and WDOG_LIMIT is unused.
  - Histogram, event and read behaviour are identical in both builds.

## Test plan
- Reset, then en=1, CHANNELS=3, channel 0 occ=0x25 for 10 cycles, then read (0,4) → rd_data=10 one cycle after rd_req. Bin (0,4) is 0x25>>3=4. Read (0,3) → 0.
- Clamp: occ=0xFF on channel 1 for 5 cycles → bin (1,15)=5. With CNT_W=8 and 300 samples → bin (1,15)=255 (saturated).
- Events: 7 ret_valid, 3 of them branches, 1 of those mispredicted, over 20 en cycles → reads (3,0..3) return 20, 7, 3, 1; read (3,5) → 0.
- Clear collision: clr asserted in the same cycle as a sample and a read of (0,4)=10 → rd_data=10. The next read of (0,4) returns 0 and the dropped sample is not counted.
- Watchdog (PERF_HIST_WDOG_EN, WDOG_LIMIT=2000):
  - 2001 en cycles with no retire → wdog_trip=1 and stays 1 after a later ret_valid; clr drops it to 0.
  - ret_valid on the trip cycle → no trip.
  - Macro undefined → wdog_trip stays 0.
- Async reset asserted mid-stream, between clk edges → all outputs 0 immediately. After release, all reads return 0.
